// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: arms on a programmed sequence of plaintexts, fires a
// fixed-length trigger window, then waits for the encryption to finish.
module trig_seq_ctrl #(
    parameter int NUM_PAT = 4,
    parameter int WIN_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data,
    input  logic         done,
    input  logic         pat_wr,
    input  logic [1:0]   pat_idx,
    input  logic [127:0] pat_val,
    output logic         Tj_Trig,
    output logic [3:0]   key_sel,
    output logic         busy,
    output logic [1:0]   match_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FIRE  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [1:0] LAST_IDX = 2'(NUM_PAT - 1);
    localparam logic [2:0] PAT_CNT  = 3'(NUM_PAT);
    localparam logic [7:0] WIN_LAST = 8'(WIN_LEN - 1);

    logic [1:0]   state_r;
    logic [1:0]   state_s;
    logic [1:0]   match_cnt_r;
    logic [1:0]   match_cnt_s;
    logic [7:0]   win_cnt_r;
    logic [7:0]   win_cnt_s;
    logic [3:0]   key_sel_r;
    logic [3:0]   key_sel_s;
    logic         tj_trig_r;
    logic         busy_r;
    logic [127:0] pat_r [NUM_PAT];
    logic [127:0] cur_pat_s;
    logic         hit_s;
    logic         first_hit_s;
    logic         pat_we_s;

    // Select the pattern expected next in the sequence
    always_comb begin
        cur_pat_s = 128'd0;
        for (int i = 0; i < NUM_PAT; i++) begin
            cur_pat_s = (match_cnt_r == 2'(i)) ? pat_r[i] : cur_pat_s;
        end
    end

    assign hit_s       = start && (data == cur_pat_s);
    assign first_hit_s = start && (data == pat_r[0]);
    assign pat_we_s    = pat_wr && !busy_r && ({1'b0, pat_idx} < PAT_CNT);

    // Next-state and counter logic of the arming / firing sequencer
    always_comb begin
        state_s     = state_r;
        match_cnt_s = match_cnt_r;
        win_cnt_s   = win_cnt_r;
        key_sel_s   = key_sel_r;
        case (state_r)
            IDLE: begin
                if (first_hit_s) begin
                    state_s     = TRACK;
                    match_cnt_s = 2'd1;
                end else begin
                    match_cnt_s = 2'd0;
                end
            end
            TRACK: begin
                if (!start) begin
                    state_s = TRACK;
                end else if (hit_s) begin
                    if (match_cnt_r == LAST_IDX) begin
                        state_s     = FIRE;
                        match_cnt_s = 2'd0;
                        win_cnt_s   = 8'd0;
                    end else begin
                        match_cnt_s = match_cnt_r + 2'd1;
                    end
                end else if (first_hit_s) begin
                    // A broken sequence may itself be the start of a new one
                    match_cnt_s = 2'd1;
                end else begin
                    state_s     = IDLE;
                    match_cnt_s = 2'd0;
                end
            end
            FIRE: begin
                if (win_cnt_r == WIN_LAST) begin
                    state_s   = HOLD;
                    win_cnt_s = 8'd0;
                end else begin
                    win_cnt_s = win_cnt_r + 8'd1;
                end
            end
            HOLD: begin
                if (done) begin
                    state_s   = IDLE;
                    key_sel_s = key_sel_r + 4'd1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s     = IDLE;
                match_cnt_s = 2'd0;
                win_cnt_s   = 8'd0;
            end
        endcase
    end

    // State, registered outputs and pattern table
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            match_cnt_r <= 2'd0;
            win_cnt_r   <= 8'd0;
            key_sel_r   <= 4'd0;
            tj_trig_r   <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_r[i] <= 128'd0;
            end
        end else begin
            state_r     <= state_s;
            match_cnt_r <= match_cnt_s;
            win_cnt_r   <= win_cnt_s;
            key_sel_r   <= key_sel_s;
            tj_trig_r   <= (state_s == FIRE);
            busy_r      <= (state_s != IDLE);
            for (int i = 0; i < NUM_PAT; i++) begin
                if (pat_we_s && (pat_idx == 2'(i))) begin
                    pat_r[i] <= pat_val;
                end
            end
        end
    end

    assign Tj_Trig   = tj_trig_r;
    assign key_sel   = key_sel_r;
    assign busy      = busy_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Self-checking bench for trig_seq_ctrl: directed table, corner sequences,
// and random stimulus against a sequence-level reference model.
module tb_trig_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_start, a_done, a_pat_wr;
    logic [127:0] a_data, a_pat_val;
    logic [1:0]   a_pat_idx;
    logic         a_trig, a_busy;
    logic [3:0]   a_key;
    logic [1:0]   a_mc;
    logic         b_start, b_done, b_pat_wr;
    logic [127:0] b_data, b_pat_val;
    logic [1:0]   b_pat_idx;
    logic         b_trig, b_busy;
    logic [3:0]   b_key;
    logic [1:0]   b_mc;

    trig_seq_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .data(a_data), .done(a_done),
        .pat_wr(a_pat_wr), .pat_idx(a_pat_idx), .pat_val(a_pat_val),
        .Tj_Trig(a_trig), .key_sel(a_key), .busy(a_busy), .match_cnt(a_mc)
    );

    trig_seq_ctrl #(.NUM_PAT(2), .WIN_LEN(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .data(b_data), .done(b_done),
        .pat_wr(b_pat_wr), .pat_idx(b_pat_idx), .pat_val(b_pat_val),
        .Tj_Trig(b_trig), .key_sel(b_key), .busy(b_busy), .match_cnt(b_mc)
    );

    typedef struct {
        logic       st;
        int         dsel;
        logic       dn;
        logic       wr;
        logic [1:0] idx;
        int         vsel;
        logic       e_trig;
        logic       e_busy;
        logic [1:0] e_mc;
        logic [3:0] e_key;
    } vec_t;

    vec_t         vecs [16];
    logic [127:0] pool [5];
    int           checks = 0;
    int           errors = 0;

    // reference model state
    logic [127:0] m_pat [4];
    int           m_m, m_left, m_fires;
    bit           m_hold, m_busy_pre;
    int           n_trig;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic t, input logic b,
                           input logic [1:0] mc, input logic [3:0] k);
        check({name, ".trig"}, {7'd0, a_trig}, {7'd0, t});
        check({name, ".busy"}, {7'd0, a_busy}, {7'd0, b});
        check({name, ".mc"},   {6'd0, a_mc},   {6'd0, mc});
        check({name, ".key"},  {4'd0, a_key},  {4'd0, k});
    endtask

    task automatic check_b(input string name, input logic t, input logic b,
                           input logic [1:0] mc, input logic [3:0] k);
        check({name, ".trig"}, {7'd0, b_trig}, {7'd0, t});
        check({name, ".busy"}, {7'd0, b_busy}, {7'd0, b});
        check({name, ".mc"},   {6'd0, b_mc},   {6'd0, mc});
        check({name, ".key"},  {4'd0, b_key},  {4'd0, k});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_start = 1'b0; a_done = 1'b0; a_pat_wr = 1'b0;
        a_data = 128'd0; a_pat_idx = 2'd0; a_pat_val = 128'd0;
    endtask

    task automatic a_go(input logic [127:0] d);
        a_start = 1'b1; a_data = d;
        tick();
        a_idle();
    endtask

    // Feed a full A,B,C,D sequence, measure the window, release with done
    task automatic run_fire(input string name, input logic [3:0] exp_key);
        a_go(pool[0]); check(name, {6'd0, a_mc}, 8'd1);
        a_go(pool[1]); check(name, {6'd0, a_mc}, 8'd2);
        a_go(pool[2]); check(name, {6'd0, a_mc}, 8'd3);
        a_go(pool[3]);
        n_trig = 0;
        for (int k = 0; k < 24; k++) begin
            if (a_trig) n_trig++;
            tick();
        end
        check({name, ".window"}, 8'(n_trig), 8'd16);
        check_a({name, ".hold"}, 1'b0, 1'b1, 2'd0, exp_key - 4'd1);
        a_done = 1'b1;
        tick();
        a_idle();
        check_a({name, ".idle"}, 1'b0, 1'b0, 2'd0, exp_key);
    endtask

    initial begin
        pool[0] = {4{32'hA0A0_1111}};
        pool[1] = {4{32'hB1B1_2222}};
        pool[2] = {4{32'hC2C2_3333}};
        pool[3] = {4{32'hD3D3_4444}};
        pool[4] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        vecs[0]  = '{1'b0, 0, 1'b0, 1'b1, 2'd0, 0, 1'b0, 1'b0, 2'd0, 4'd0};
        vecs[1]  = '{1'b0, 0, 1'b0, 1'b1, 2'd1, 1, 1'b0, 1'b0, 2'd0, 4'd0};
        vecs[2]  = '{1'b0, 0, 1'b0, 1'b1, 2'd2, 2, 1'b0, 1'b0, 2'd0, 4'd0};
        vecs[3]  = '{1'b0, 0, 1'b0, 1'b1, 2'd3, 3, 1'b0, 1'b0, 2'd0, 4'd0};
        vecs[4]  = '{1'b1, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd1, 4'd0};
        vecs[5]  = '{1'b0, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd1, 4'd0};
        vecs[6]  = '{1'b1, 1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd2, 4'd0};
        vecs[7]  = '{1'b1, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd1, 4'd0};
        vecs[8]  = '{1'b1, 1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd2, 4'd0};
        vecs[9]  = '{1'b1, 4, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0, 2'd0, 4'd0};
        vecs[10] = '{1'b1, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd1, 4'd0};
        vecs[11] = '{1'b0, 0, 1'b0, 1'b1, 2'd0, 4, 1'b0, 1'b1, 2'd1, 4'd0};
        vecs[12] = '{1'b1, 1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd2, 4'd0};
        vecs[13] = '{1'b1, 2, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd3, 4'd0};
        vecs[14] = '{1'b0, 0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 1'b1, 2'd3, 4'd0};
        vecs[15] = '{1'b1, 3, 1'b0, 1'b0, 2'd0, 0, 1'b1, 1'b1, 2'd0, 4'd0};

        a_idle();
        b_start = 1'b0; b_done = 1'b0; b_pat_wr = 1'b0;
        b_data = 128'd0; b_pat_idx = 2'd0; b_pat_val = 128'd0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_a("reset_a", 1'b0, 1'b0, 2'd0, 4'd0);
        check_b("reset_b", 1'b0, 1'b0, 2'd0, 4'd0);
        rst = 1'b1;
        tick();

        // Two-pattern, one-cycle-window instance
        b_pat_wr = 1'b1; b_pat_idx = 2'd0; b_pat_val = pool[0]; tick();
        b_pat_idx = 2'd1; b_pat_val = pool[1]; tick();
        b_pat_idx = 2'd2; b_pat_val = pool[2]; tick();
        b_pat_wr = 1'b0;
        check_b("b_load", 1'b0, 1'b0, 2'd0, 4'd0);
        b_start = 1'b1; b_data = pool[0]; tick();
        check_b("b_a1", 1'b0, 1'b1, 2'd1, 4'd0);
        b_data = pool[2]; tick();
        check_b("b_bad_idx", 1'b0, 1'b0, 2'd0, 4'd0);
        b_data = pool[0]; tick();
        b_data = pool[1]; tick();
        b_start = 1'b0; b_done = 1'b1;
        check_b("b_fire", 1'b1, 1'b1, 2'd0, 4'd0);
        tick();
        check_b("b_fire_done", 1'b0, 1'b1, 2'd0, 4'd0);
        tick();
        b_done = 1'b0;
        check_b("b_hold_done", 1'b0, 1'b0, 2'd0, 4'd1);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            a_start = vecs[i].st; a_data = pool[vecs[i].dsel]; a_done = vecs[i].dn;
            a_pat_wr = vecs[i].wr; a_pat_idx = vecs[i].idx; a_pat_val = pool[vecs[i].vsel];
            tick();
            a_idle();
            check_a($sformatf("vec%0d", i), vecs[i].e_trig, vecs[i].e_busy, vecs[i].e_mc, vecs[i].e_key);
        end

        // Window length with start/done noise inside FIRE
        n_trig = 1;
        for (int k = 0; k < 40; k++) begin
            if (k == 2) begin
                a_done = 1'b1; a_start = 1'b1; a_data = pool[0];
            end
            tick();
            a_idle();
            if (a_trig) n_trig++;
        end
        check("window1", 8'(n_trig), 8'd16);
        check_a("hold1", 1'b0, 1'b1, 2'd0, 4'd0);
        a_done = 1'b1; tick(); a_idle();
        check_a("idle1", 1'b0, 1'b0, 2'd0, 4'd1);

        // Firings 2..17: key_sel wraps 15 -> 0
        for (int f = 2; f <= 17; f++) begin
            run_fire($sformatf("fire%0d", f), 4'(f));
        end

        // Asynchronous reset in the fifth window cycle
        a_go(pool[0]); a_go(pool[1]); a_go(pool[2]); a_go(pool[3]);
        repeat (4) tick();
        check("pre_rst_trig", {7'd0, a_trig}, 8'd1);
        #2 rst = 1'b0;
        #1;
        check_a("async_rst", 1'b0, 1'b0, 2'd0, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        check_a("post_rst_idle", 1'b0, 1'b0, 2'd0, 4'd0);
        a_go(128'd0); check("zero_tbl0", {6'd0, a_mc}, 8'd1);
        a_go(128'd0); check("zero_tbl1", {6'd0, a_mc}, 8'd2);
        a_go(128'd0); check("zero_tbl2", {6'd0, a_mc}, 8'd3);
        a_go(128'd0); check("zero_tbl3", {7'd0, a_trig}, 8'd1);

        // Random phase against the reference model
        rst = 1'b0; #2; rst = 1'b1;
        for (int i = 0; i < 4; i++) m_pat[i] = 128'd0;
        m_m = 0; m_left = 0; m_fires = 0; m_hold = 1'b0;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            a_start  = 1'($urandom_range(0, 1));
            r        = $urandom_range(0, 9);
            a_data   = (r < 6) ? m_pat[m_m] : ((r < 8) ? m_pat[0] : pool[$urandom_range(0, 4)]);
            a_done   = ($urandom_range(0, 3) == 0);
            a_pat_wr = ($urandom_range(0, 7) == 0);
            a_pat_idx = 2'($urandom_range(0, 3));
            a_pat_val = pool[$urandom_range(0, 4)];
            m_busy_pre = (m_m > 0) || (m_left > 0) || m_hold;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_hold = 1'b1;
            end else if (m_hold) begin
                if (a_done) begin
                    m_hold = 1'b0;
                    m_fires++;
                end
            end else if (a_start) begin
                if (a_data == m_pat[m_m]) begin
                    if (m_m == 3) begin
                        m_m = 0;
                        m_left = 16;
                    end else begin
                        m_m++;
                    end
                end else if (a_data == m_pat[0]) begin
                    m_m = 1;
                end else begin
                    m_m = 0;
                end
            end
            if (a_pat_wr && !m_busy_pre) m_pat[a_pat_idx] = a_pat_val;
            tick();
            check_a($sformatf("rand%0d", cyc), (m_left > 0), (m_m > 0) || (m_left > 0) || m_hold,
                    2'(m_m), 4'(m_fires % 16));
        end
        a_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
